sort_result_streamer: RTL and testbench

SORT_RESULT_STREAMER -- requirements
Module: sort_result_streamer

---
 rtl/sort_pkg.sv | 20 ++
 rtl/sort_result_streamer.sv | 107 ++++++++++
 tb/tb_sort_result_streamer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared types and constants for the sorted-vector result streamer.
// Holds the streamer state encoding and the drop-counter width.
// Imported by sort_result_streamer; carries no logic of its own.
package sort_pkg;

    // Streamer control state: waiting for a vector, or emitting one.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Width of the saturating dropped-vector counter.
    localparam int DROP_CNT_W = 8;

    // Saturating increment for the drop counter.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sort_result_streamer.sv
// Purpose: serialises one sorted N-word vector into a valid/ready word stream, index 0 first.
// Latency: first word is valid the cycle after y_valid; back-to-back vectors chain without a bubble.
// Backpressure: m_ready low holds the current word; a vector arriving mid-stream is dropped and counted.
module sort_result_streamer
    import sort_pkg::*;
#(
    parameter int LOG_INPUT_NUM = 4,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]  y,
    input  logic                                      y_valid,
    output logic [DATA_WIDTH-1:0]                     m_data,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [LOG_INPUT_NUM-1:0]                  m_index,
    output logic                                      m_last,
    output logic                                      busy,
    output logic                                      overflow,
    output logic [DROP_CNT_W-1:0]                     drop_cnt
);

    localparam int N = 2**LOG_INPUT_NUM;
    localparam logic [LOG_INPUT_NUM-1:0] LAST_IDX = LOG_INPUT_NUM'(N-1);

    state_t                     r_state;
    logic [LOG_INPUT_NUM-1:0]   r_idx;
    logic                       r_overflow;
    logic [DROP_CNT_W-1:0]      r_drop_cnt;
    logic [DATA_WIDTH-1:0]      r_buf [N];

    logic w_streaming;
    logic w_xfer;
    logic w_last_xfer;
    logic w_capture;
    logic w_drop;

    // Handshake and vector acceptance decode. A new vector is taken only when
    // the buffer is free this cycle: idle, or the final word is leaving now.
    always_comb begin
        w_streaming = (r_state == STREAM);
        w_xfer      = w_streaming && m_ready;
        w_last_xfer = w_xfer && (r_idx == LAST_IDX);
        w_capture   = !rst && y_valid && (!w_streaming || w_last_xfer);
        w_drop      = y_valid && w_streaming && !w_last_xfer;
    end

    // Vector buffer: loaded only on acceptance, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int j = 0; j < N; j++) begin
                r_buf[j] <= y[DATA_WIDTH*j +: DATA_WIDTH];
            end
        end
    end

    // Control FSM: state, word index and drop bookkeeping; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (y_valid) begin
                        r_state <= STREAM;
                        r_idx   <= '0;
                    end
                end
                STREAM: begin
                    if (w_last_xfer) begin
                        // Reload to 0 either way; stay busy only if a new vector arrived.
                        r_idx   <= '0;
                        r_state <= y_valid ? STREAM : IDLE;
                    end else if (w_xfer) begin
                        r_idx <= r_idx + LOG_INPUT_NUM'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                end
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    // Output view: all fields come straight from registers; data is forced to
    // zero when idle so the unreset buffer never shows on the bus.
    always_comb begin
        m_valid  = w_streaming;
        busy     = w_streaming;
        m_index  = r_idx;
        m_last   = w_streaming && (r_idx == LAST_IDX);
        m_data   = w_streaming ? r_buf[r_idx] : '0;
        overflow = r_overflow;
        drop_cnt = r_drop_cnt;
    end

endmodule

// File: tb/tb_sort_result_streamer.sv
// Testbench for sort_result_streamer with N=4 words of 8 bits.
// Directed scenarios followed by randomized traffic, checked every cycle.
// Reference model: a queue of words still owed for the held vector.
module tb_sort_result_streamer;

    localparam int LOG_N = 2;
    localparam int DW    = 8;
    localparam int N     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW*N-1:0]   y;
    logic              y_valid;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ready;
    logic [LOG_N-1:0]  m_index;
    logic              m_last;
    logic              busy;
    logic              overflow;
    logic [7:0]        drop_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int q_words[$];
    bit mdl_ovf;
    int mdl_drops;

    sort_result_streamer #(.LOG_INPUT_NUM(LOG_N), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .y        (y),
        .y_valid  (y_valid),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_index  (m_index),
        .m_last   (m_last),
        .busy     (busy),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model's current view.
    task automatic check_all();
        bit v;
        v = (q_words.size() > 0);
        check("m_valid", {31'd0, m_valid}, {31'd0, v});
        check("busy", {31'd0, busy}, {31'd0, v});
        check("overflow", {31'd0, overflow}, {31'd0, mdl_ovf});
        check("drop_cnt", {24'd0, drop_cnt}, 32'(mdl_drops));
        if (v) begin
            check("m_data", {24'd0, m_data}, 32'(q_words[0]));
            check("m_index", {30'd0, m_index}, 32'(N - q_words.size()));
            check("m_last", {31'd0, m_last}, {31'd0, q_words.size() == 1});
        end
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step(input logic r, input logic yv, input logic [DW*N-1:0] yy, input logic rdy);
        if (r) begin
            q_words.delete();
            mdl_ovf   = 1'b0;
            mdl_drops = 0;
        end else begin
            if (q_words.size() > 0 && rdy) void'(q_words.pop_front());
            if (yv) begin
                if (q_words.size() == 0) begin
                    for (int j = 0; j < N; j++) q_words.push_back(int'(yy[DW*j +: DW]));
                end else begin
                    mdl_ovf = 1'b1;
                    if (mdl_drops < 255) mdl_drops++;
                end
            end
        end
    endtask

    // Apply inputs for one cycle, clock, then check outputs on the falling edge.
    task automatic cyc(input logic r, input logic yv, input logic [DW*N-1:0] yy, input logic rdy);
        rst = r; y_valid = yv; y = yy; m_ready = rdy;
        model_step(r, yv, yy, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; y_valid = 1'b0; y = '0; m_ready = 1'b0;
        mdl_ovf = 1'b0; mdl_drops = 0;
        @(negedge clk);

        // Reset state.
        cyc(1, 0, '0, 0);
        cyc(1, 0, '0, 0);
        check("rst_m_data", {24'd0, m_data}, 32'h0);
        check("rst_m_last", {31'd0, m_last}, 32'h0);
        check("rst_m_index", {30'd0, m_index}, 32'h0);

        // Straight stream with m_ready held high.
        cyc(0, 1, 32'h40302010, 1);
        check("first_word", {24'd0, m_data}, 32'h10);
        for (int i = 0; i < N; i++) cyc(0, 0, '0, 1);
        check("done_valid", {31'd0, m_valid}, 32'h0);
        check("done_busy", {31'd0, busy}, 32'h0);

        // Same vector with m_ready toggling: each word held while stalled.
        cyc(0, 1, 32'h40302010, 0);
        for (int i = 0; i < 2*N; i++) cyc(0, 0, '0, (i % 2) == 0);
        check("toggle_done", {31'd0, m_valid}, 32'h0);

        // Back-to-back: new vector offered exactly as the last word leaves.
        cyc(0, 1, 32'h40302010, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        check("pre_chain_last", {24'd0, m_data}, 32'h40);
        cyc(0, 1, 32'h04030201, 1);
        check("chain_valid", {31'd0, m_valid}, 32'h1);
        check("chain_data", {24'd0, m_data}, 32'h01);
        check("chain_index", {30'd0, m_index}, 32'h0);
        check("chain_ovf", {31'd0, overflow}, 32'h0);
        for (int i = 0; i < N; i++) cyc(0, 0, '0, 1);

        // Drop while index=1, then stream the rest unchanged.
        cyc(0, 1, 32'h40302010, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 1, 32'hAABBCCDD, 0);
        check("drop_ovf", {31'd0, overflow}, 32'h1);
        check("drop_cnt1", {24'd0, drop_cnt}, 32'd1);
        check("drop_keep", {24'd0, m_data}, 32'h20);
        // Saturation: 300 more drops with the stream stalled.
        for (int i = 0; i < 300; i++) cyc(0, 1, 32'(i), 0);
        check("drop_sat", {24'd0, drop_cnt}, 32'd255);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 1);

        // Reset mid-stream at index=2.
        cyc(0, 1, 32'h40302010, 1);
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        check("pre_rst_index", {30'd0, m_index}, 32'd2);
        cyc(1, 0, '0, 1);
        check("rst_mid_valid", {31'd0, m_valid}, 32'h0);
        check("rst_mid_drop", {24'd0, drop_cnt}, 32'h0);
        cyc(0, 1, 32'h08070605, 1);
        check("restart_data", {24'd0, m_data}, 32'h05);
        for (int i = 0; i < N; i++) cyc(0, 0, '0, 1);

        // Reset and y_valid together: stays idle.
        cyc(1, 1, 32'h11223344, 1);
        check("rst_yv_valid", {31'd0, m_valid}, 32'h0);
        cyc(0, 0, '0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 63) == 0,
                $urandom_range(0, 3) == 0,
                $urandom(),
                $urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
